// File: rtl/wb_dma_periph_req.sv
// Hardware-handshake request generator for one wb_dma channel: turns peripheral FIFO level
// into chunked dma_req/ack handshakes, with next-descriptor reload and abort/restart.
module wb_dma_periph_req #(
  parameter int unsigned LW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [11:0]   total_i,
  input  logic [8:0]    chunk_i,
  input  logic          auto_nd_i,
  input  logic          abort_i,
  input  logic [LW-1:0] level_i,
  input  logic          dma_ack_i,
  output logic          dma_req_o,
  output logic          dma_nd_o,
  output logic          dma_rest_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [11:0]   remain_o,
  output logic          err_o
);

  localparam int unsigned CW = (LW > 12) ? LW : 12;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StReq  = 2'd2;
  localparam logic [1:0] StGap  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [11:0] remain_q, remain_d;
  logic        req_q, req_d;
  logic        nd_q, nd_d;
  logic        rest_q, rest_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [11:0] chunk_eff;
  logic [11:0] sz;
  logic [CW-1:0] level_ext;
  logic [CW-1:0] sz_ext;

  always_comb begin
    chunk_eff = (chunk_i == 9'd0) ? 12'd1 : {3'b000, chunk_i};
    sz        = (chunk_eff < remain_q) ? chunk_eff : remain_q;
    level_ext = CW'(level_i);
    sz_ext    = CW'(sz);
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    req_d    = req_q;
    nd_d     = 1'b0;
    rest_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;

    // An ack with no request outstanding is a protocol violation and is otherwise ignored.
    if (dma_ack_i && !req_q) begin
      err_d = 1'b1;
    end

    if (abort_i && (state_q != StIdle)) begin
      state_d  = StIdle;
      remain_d = 12'd0;
      req_d    = 1'b0;
      rest_d   = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i && !busy_q) begin
            err_d = 1'b0;
            if (total_i != 12'd0) begin
              remain_d = total_i;
              state_d  = StWait;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StWait: begin
          if (level_ext >= sz_ext) begin
            req_d   = 1'b1;
            state_d = StReq;
          end
        end
        StReq: begin
          if (dma_ack_i) begin
            remain_d = (remain_q > sz) ? (remain_q - sz) : 12'd0;
            req_d    = 1'b0;
            state_d  = StGap;
          end
        end
        StGap: begin
          if (remain_q != 12'd0) begin
            state_d = StWait;
          end else if (auto_nd_i && (total_i != 12'd0)) begin
            nd_d     = 1'b1;
            remain_d = total_i;
            state_d  = StWait;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // busy rises with the first active state and falls one cycle after returning to idle.
    busy_d = (state_d != StIdle) || (state_q != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      remain_q <= 12'd0;
      req_q    <= 1'b0;
      nd_q     <= 1'b0;
      rest_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      req_q    <= req_d;
      nd_q     <= nd_d;
      rest_q   <= rest_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign dma_req_o  = req_q;
  assign dma_nd_o   = nd_q;
  assign dma_rest_o = rest_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign remain_o   = remain_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_wb_dma_periph_req.sv
// Directed and randomized bench for wb_dma_periph_req; expected chunk sequences come from
// a transaction-level model of the buffer (sizes = min(max(chunk,1), remaining)).
module tb_wb_dma_periph_req;

  localparam int unsigned LW = 6;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [11:0]   total_i = '0;
  logic [8:0]    chunk_i = '0;
  logic          auto_nd_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [LW-1:0] level_i = '0;
  logic          dma_ack_i = 1'b0;
  logic          dma_req_o, dma_nd_o, dma_rest_o, busy_o, done_o, err_o;
  logic [11:0]   remain_o;

  int checks = 0;
  int errors = 0;

  // Edge/pulse counters sampled at the clock edge.
  logic req_prev = 1'b0;
  int   rises = 0;
  int   dones = 0;
  int   nds = 0;
  int   rests = 0;

  wb_dma_periph_req #(.LW(LW)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .total_i    (total_i),
    .chunk_i    (chunk_i),
    .auto_nd_i  (auto_nd_i),
    .abort_i    (abort_i),
    .level_i    (level_i),
    .dma_ack_i  (dma_ack_i),
    .dma_req_o  (dma_req_o),
    .dma_nd_o   (dma_nd_o),
    .dma_rest_o (dma_rest_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .remain_o   (remain_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    req_prev <= (dma_req_o === 1'b1);
    if (dma_req_o === 1'b1 && !req_prev) rises <= rises + 1;
    if (done_o === 1'b1) dones <= dones + 1;
    if (dma_nd_o === 1'b1) nds <= nds + 1;
    if (dma_rest_o === 1'b1) rests <= rests + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_sz(input int chunk, input int rem);
    int c;
    c = (chunk == 0) ? 1 : chunk;
    return (c < rem) ? c : rem;
  endfunction

  // Wait (bounded) for dma_req_o to rise; optionally randomize level and verify the
  // level seen in the cycle before the rise covered the request size.
  task automatic wait_req(input string tag, input int need, input bit rand_lvl);
    int n;
    int prev;
    n = 0;
    prev = int'(level_i);
    while (dma_req_o !== 1'b1 && n < 200) begin
      if (rand_lvl) level_i = LW'($urandom_range(0, 63));
      prev = int'(level_i);
      tick();
      n++;
    end
    check({tag, "_req_rise"}, {31'd0, dma_req_o}, 32'd1);
    if (rand_lvl) check({tag, "_level_ok"}, {31'd0, prev >= need}, 32'd1);
  endtask

  task automatic ack_chunk(input string tag, input int delay, input int exp_rem, input bit rand_lvl);
    for (int i = 0; i < delay; i++) begin
      if (rand_lvl) level_i = LW'($urandom_range(0, 63));
      tick();
      check({tag, "_req_held"}, {31'd0, dma_req_o}, 32'd1);
    end
    dma_ack_i = 1'b1;
    tick();
    dma_ack_i = 1'b0;
    check({tag, "_req_drop"}, {31'd0, dma_req_o}, 32'd0);
    check({tag, "_remain"}, {20'd0, remain_o}, exp_rem);
  endtask

  task automatic finish_done(input string tag);
    check({tag, "_done_early"}, {31'd0, done_o}, 32'd0);
    tick();
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_no_nd"}, {31'd0, dma_nd_o}, 32'd0);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, "_busy_fall"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic do_start(input int total, input int chunk);
    total_i = 12'(total);
    chunk_i = 9'(chunk);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int r0, d0, n0, s0;
    int rem, sz;
    int exp_q[$];

    // Reset state
    tick();
    tick();
    check("rst_req", {31'd0, dma_req_o}, 32'd0);
    check("rst_nd", {31'd0, dma_nd_o}, 32'd0);
    check("rst_rest", {31'd0, dma_rest_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_remain", {20'd0, remain_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    // Basic chunking: 10 words in chunks of 4
    r0 = rises; d0 = dones; n0 = nds;
    level_i = 6'd63;
    do_start(10, 4);
    check("basic_busy", {31'd0, busy_o}, 32'd1);
    check("basic_req_not_yet", {31'd0, dma_req_o}, 32'd0);
    tick();
    check("basic_req_t2", {31'd0, dma_req_o}, 32'd1);
    ack_chunk("basic1", 3, 6, 1'b0);
    wait_req("basic2", 0, 1'b0);
    ack_chunk("basic2", 3, 2, 1'b0);
    wait_req("basic3", 0, 1'b0);
    ack_chunk("basic3", 3, 0, 1'b0);
    finish_done("basic");
    check("basic_rises", rises - r0, 32'd3);
    check("basic_dones", dones - d0, 32'd1);
    check("basic_nds", nds - n0, 32'd0);

    // Level gating
    level_i = 6'd5;
    do_start(8, 8);
    for (int i = 0; i < 5; i++) tick();
    check("gate_hold_off", {31'd0, dma_req_o}, 32'd0);
    level_i = 6'd8;
    tick();
    check("gate_req_rise", {31'd0, dma_req_o}, 32'd1);
    level_i = 6'd0;
    ack_chunk("gate", 3, 0, 1'b0);
    finish_done("gate");

    // Auto next-descriptor, then abort with a coincident ack
    d0 = dones; n0 = nds; s0 = rests;
    level_i = 6'd63;
    auto_nd_i = 1'b1;
    do_start(4, 4);
    wait_req("nd", 0, 1'b0);
    ack_chunk("nd", 1, 0, 1'b0);
    check("nd_early", {31'd0, dma_nd_o}, 32'd0);
    tick();
    check("nd_pulse", {31'd0, dma_nd_o}, 32'd1);
    check("nd_reload", {20'd0, remain_o}, 32'd4);
    tick();
    check("nd_one_cycle", {31'd0, dma_nd_o}, 32'd0);
    check("nd_rereq", {31'd0, dma_req_o}, 32'd1);
    abort_i = 1'b1;
    dma_ack_i = 1'b1;
    tick();
    abort_i = 1'b0;
    dma_ack_i = 1'b0;
    check("abort_rest", {31'd0, dma_rest_o}, 32'd1);
    check("abort_req", {31'd0, dma_req_o}, 32'd0);
    check("abort_remain", {20'd0, remain_o}, 32'd0);
    check("abort_no_err", {31'd0, err_o}, 32'd0);
    tick();
    check("abort_rest_pulse", {31'd0, dma_rest_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_no_gap", {31'd0, done_o | dma_nd_o}, 32'd0);
    check("nd_count", nds - n0, 32'd1);
    check("nd_no_done", dones - d0, 32'd0);
    check("abort_rest_count", rests - s0, 32'd1);
    auto_nd_i = 1'b0;
    do_start(2, 2);
    wait_req("post_abort", 0, 1'b0);
    ack_chunk("post_abort", 0, 0, 1'b0);
    finish_done("post_abort");

    // Stray ack while idle sets a sticky error
    dma_ack_i = 1'b1;
    tick();
    dma_ack_i = 1'b0;
    check("err_set", {31'd0, err_o}, 32'd1);
    tick();
    tick();
    check("err_sticky", {31'd0, err_o}, 32'd1);
    check("err_no_effect", {31'd0, busy_o | done_o | dma_req_o}, 32'd0);

    // chunk 0 behaves as 1; the start clears the error
    r0 = rises;
    do_start(3, 0);
    check("err_clear", {31'd0, err_o}, 32'd0);
    wait_req("c0_1", 0, 1'b0);
    ack_chunk("c0_1", 1, 2, 1'b0);
    wait_req("c0_2", 0, 1'b0);
    ack_chunk("c0_2", 1, 1, 1'b0);
    wait_req("c0_3", 0, 1'b0);
    ack_chunk("c0_3", 1, 0, 1'b0);
    finish_done("c0");
    check("c0_rises", rises - r0, 32'd3);

    // Zero-length buffer
    do_start(0, 4);
    check("zero_done", {31'd0, done_o}, 32'd1);
    check("zero_busy", {31'd0, busy_o}, 32'd0);
    tick();
    check("zero_done_pulse", {31'd0, done_o}, 32'd0);
    check("zero_busy2", {31'd0, busy_o}, 32'd0);

    // Reset mid-transfer
    s0 = rests;
    do_start(8, 4);
    wait_req("rstmid", 0, 1'b0);
    rst_i = 1'b1;
    start_i = 1'b1;
    tick();
    check("rstmid_req", {31'd0, dma_req_o}, 32'd0);
    check("rstmid_busy", {31'd0, busy_o}, 32'd0);
    check("rstmid_remain", {20'd0, remain_o}, 32'd0);
    check("rstmid_pulses", {29'd0, dma_rest_o, dma_nd_o, done_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    start_i = 1'b0;
    tick();
    check("rstmid_idle", {30'd0, busy_o, dma_req_o}, 32'd0);
    check("rstmid_no_rest", rests - s0, 32'd0);

    // Randomized buffers against the transaction model
    for (int b = 0; b < 6; b++) begin
      int tot, chk, dly;
      tot = int'($urandom_range(1, 40));
      chk = int'($urandom_range(0, 12));
      exp_q.delete();
      rem = tot;
      while (rem > 0) begin
        rem = rem - model_sz(chk, rem);
        exp_q.push_back(rem);
      end
      r0 = rises;
      rem = tot;
      do_start(tot, chk);
      check("rnd_remain_load", {20'd0, remain_o}, tot);
      foreach (exp_q[k]) begin
        sz = rem - exp_q[k];
        wait_req("rnd", sz, 1'b1);
        dly = int'($urandom_range(0, 3));
        ack_chunk("rnd", dly, exp_q[k], 1'b1);
        rem = exp_q[k];
      end
      finish_done("rnd");
      check("rnd_rises", rises - r0, exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
